// File: rtl/adder_arbiter.sv
// Round-robin arbiter and sequencer that shares one external 8-bit adder
// among NUM_REQ requesters.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  per-requester request valid
//   req_ready  per-requester accept (one-hot or zero, combinational in IDLE)
//   req_a/b    packed operands, requester i on bits [8i+7:8i]
//   add_a/b    registered operands to the shared adder
//   add_sum    adder result, bit 8 is carry-out
//   rsp_*      response channel (valid/ready, sum, owning requester id)
//   busy       high whenever the FSM is not idle
module adder_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  output logic [7:0]           add_a,
  output logic [7:0]           add_b,
  input  logic [8:0]           add_sum,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [8:0]           rsp_sum,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [7:0]      add_a_q, add_a_d;
  logic [7:0]      add_b_q, add_b_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [8:0]      rsp_sum_q, rsp_sum_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;

  // Arbitration result: first valid requester at or after ptr, wrapping.
  logic            found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] grant_nxt;
  logic [7:0]      sel_a;
  logic [7:0]      sel_b;

  always_comb begin
    int unsigned idx;
    found     = 1'b0;
    grant_idx = '0;
    grant_nxt = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = ID_W'(idx);
        grant_nxt = ID_W'((idx + 1) % NUM_REQ);
        sel_a     = req_a[idx*8 +: 8];
        sel_b     = req_b[idx*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
    req_ready   = '0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          req_ready[grant_idx] = 1'b1;
          add_a_d  = sel_a;
          add_b_d  = sel_b;
          rsp_id_d = grant_idx;
          ptr_d    = grant_nxt;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        rsp_sum_d   = add_sum;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // No grant may be seen while reset is held.
    if (rst) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one adder_8bit instance among NUM_REQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and drives registered operands into the shared adder.
- Captures the adder's sum and returns it with the winning requester's ID over one valid/ready response channel.
- Sits between requester agents and the single adder datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, requester ID width, equal to clog2(NUM_REQ)

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester grant/accept; at most one bit high
- req_a  input  NUM_REQ*8  packed operand A; requester i uses bits [8i+7:8i]
- req_b  input  NUM_REQ*8  packed operand B, same packing
- add_a  output  8  operand A to shared adder_8bit.operand_a, registered
- add_b  output  8  operand B to shared adder_8bit.operand_b, registered
- add_sum  input  9  adder_8bit.sum; bit 8 is carry-out
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer ready
- rsp_sum  output  9  captured sum including carry
- rsp_id  output  ID_W  index of the requester that owns the response
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, ptr=0, add_a=0, add_b=0, rsp_valid=0, rsp_sum=0, rsp_id=0, busy=0; req_ready forced to all-zero while rst=1.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - If req_valid is nonzero, select the first set bit searching from ptr upward and wrapping modulo NUM_REQ; call it g.
  - req_ready[g]=1, combinationally, in that same cycle; no other bit is high.
  - On the clock edge: add_a<=req_a[g], add_b<=req_b[g], rsp_id<=g, ptr<=(g+1) mod NUM_REQ, state<=CALC.
  - If no request is valid, stay in IDLE, req_ready=0 and ptr unchanged.
- CALC:
  - The adder settles on the registered operands.
  - On the clock edge: rsp_sum<=add_sum, rsp_valid<=1, state<=RESP.
  - req_ready=0.
- RESP:
  - Hold rsp_valid, rsp_sum and rsp_id stable until rsp_ready=1.
  - On a cycle with rsp_valid & rsp_ready: rsp_valid<=0, state<=IDLE.
  - req_ready=0 throughout.
- Latency: grant at cycle T; rsp_valid high from T+2. Minimum 3 cycles per operation (back-to-back when rsp_ready is held at 1).
- Handshake rules:
  - A requester holds req_valid, req_a and req_b stable until it sees req_ready.
  - A requester may drop req_valid before being granted; this is not an error.
  - req_ready never rises without the matching req_valid.
- Arithmetic: unsigned 8+8 into 9 bits; rsp_sum[8] is the carry (255+255=510=9'h1FE). No saturation.
- Fairness: after a grant to g, g has the lowest priority. Any continuously valid requester is granted within NUM_REQ operations.
- Simultaneous events:
  - Requests arriving in CALC or RESP wait; arbitration happens only in IDLE.
  - The response handshake and a new request in the same RESP cycle: the new request is granted in the next cycle (IDLE).
- Reset mid-operation: rst in CALC or RESP aborts the in-flight operation. No response is emitted, and all registers return to their reset values on that edge.
- add_a and add_b hold their last values outside CALC.

Test Plan:
- Single request: req_valid=0001, req_a[0]=10, req_b[0]=20 -> req_ready=0001 one cycle; 2 cycles later rsp_valid=1, rsp_sum=30, rsp_id=0.
- Carry: requester 2 sends 200+100 -> rsp_sum=9'd300 (bit 8 set), rsp_id=2; then 255+255 -> rsp_sum=510.
- Round-robin: req_valid=1111 held with rsp_ready=1 -> grants in order 0,1,2,3,0, one every 3 cycles; each rsp_id matches its requester's operands (e.g. 15+25=40 for ID 1).
- Backpressure: response pending and rsp_ready=0 for 5 cycles -> rsp_valid, rsp_sum and rsp_id stable; req_ready stays 0 despite other requests; grant follows the handshake.
- Wrap and skip: ptr=3, req_valid=0101 -> grant 0 and ptr becomes 1; the next grant goes to 2.
- Reset mid-op: rst asserted in CALC -> next cycle rsp_valid=0, busy=0, ptr=0; no response is ever produced for the aborted request.
